// File: rtl/unary_add_pkg.sv
// ---------------------------------------------------------------------------
// unary_add_pkg
//   Shared definitions for the unary accumulator family: the controller state
//   encoding, default parameter values and a parameter legality check.
//   Imported by unary_popcount and unary_add_nmod.
// ---------------------------------------------------------------------------
package unary_add_pkg;

  // Default configuration: two unary lanes summed modulo 6.
  localparam int UA_DEF_N_IN  = 2;
  localparam int UA_DEF_MOD   = 6;
  localparam int UA_DEF_CNT_W = 4;

  // Controller states: wait for start, sum lanes, replay the residue.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } ua_state_t;

  // The modulus must hold at least two values, and the lane count is kept
  // below it so a single sample can wrap the accumulator at most once.
  function automatic bit ua_params_legal(input int mod_v, input int n_in_v);
    return (mod_v >= 2) && (n_in_v >= 1) && (n_in_v <= mod_v - 1);
  endfunction

endpackage

// File: rtl/unary_popcount.sv
// ---------------------------------------------------------------------------
// unary_popcount
//   Combinational count of asserted unary lanes.
//   Ports:
//     lanes_i  [N_IN-1:0]  unary lanes, one unit per asserted bit
//     count_o  [PW-1:0]    number of asserted lanes, PW = $clog2(N_IN+1)
// ---------------------------------------------------------------------------
module unary_popcount
  import unary_add_pkg::*;
#(
  parameter int N_IN = UA_DEF_N_IN,
  localparam int PW  = $clog2(N_IN + 1)
) (
  input  logic [N_IN-1:0] lanes_i,
  output logic [PW-1:0]   count_o
);

  // Simple ripple sum of the lanes; N_IN is small for unary front-ends.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < N_IN; i++) begin
      count_o = count_o + PW'(lanes_i[i]);
    end
  end

endmodule

// File: rtl/unary_add_nmod.sv
// ---------------------------------------------------------------------------
// unary_add_nmod
//   Unary (pulse-count) accumulator: sums N_IN unary lanes modulo MOD during
//   an operation framed by start/last, reports wrap-arounds on carry and a
//   saturating wrap counter, then replays the residue as a unary pulse train
//   on dout and closes with a one-cycle done pulse.
//
//   Configuration macro: UNARY_ADD_SAT_EN
//     defined   -> accumulator clamps at MOD-1, carry is sticky until the
//                  next start, carry_cnt counts overflowing samples
//     undefined -> modulo wrap, carry is a one-cycle pulse per wrap
//
//   Ports:
//     clk        in   1      clock, rising edge
//     rst_n      in   1      asynchronous active-low reset
//     en         in   1      clock enable; 0 freezes state/count/carry_cnt
//     start      in   1      begin an operation (IDLE only)
//     din        in   N_IN   unary lanes, accumulated in ACCUM
//     last       in   1      final din sample of the operation (ACCUM only)
//     busy       out  1      high while not IDLE
//     dout       out  1      unary replay of the residue
//     carry      out  1      wrap / overflow indication
//     carry_cnt  out  CNT_W  wraps seen in the current operation
//     done       out  1      one-cycle pulse at the end of the replay
// ---------------------------------------------------------------------------
module unary_add_nmod
  import unary_add_pkg::*;
#(
  parameter int N_IN  = UA_DEF_N_IN,
  parameter int MOD   = UA_DEF_MOD,
  parameter int CNT_W = UA_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [N_IN-1:0]  din,
  input  logic             last,
  output logic             busy,
  output logic             dout,
  output logic             carry,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             done
);

  localparam int CW = $clog2(MOD);
  localparam int PW = $clog2(N_IN + 1);

  // Constants pre-sized to the accumulator arithmetic width.
  localparam logic [CW:0]   MOD_S   = (CW + 1)'(MOD);
  localparam logic [CW-1:0] MAX_CNT = CW'(MOD - 1);

  // Refuse to elaborate with a configuration that could wrap twice a cycle.
  if (!ua_params_legal(MOD, N_IN) || (CNT_W < 1)) begin : g_bad_params
    $error("unary_add_nmod: illegal parameters MOD=%0d N_IN=%0d CNT_W=%0d",
           MOD, N_IN, CNT_W);
  end

  ua_state_t        state_q,     state_d;
  logic [CW-1:0]    count_q,     count_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
  logic             dout_q,      dout_d;
  logic             carry_q,     carry_d;
  logic             done_q,      done_d;

  logic [PW-1:0]    pop;
  logic [CW:0]      sum;
  logic             ovf;

  unary_popcount #(
    .N_IN (N_IN)
  ) u_popcount (
    .lanes_i (din),
    .count_o (pop)
  );

  // One extra bit keeps count+pop exact so the wrap test cannot alias.
  assign sum = {1'b0, count_q} + (CW + 1)'(pop);
  assign ovf = (sum >= MOD_S);

  // Next-state logic. Nothing advances without en; the one-cycle outputs
  // (dout, done and the carry pulse) default low so they drop while frozen.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    carry_cnt_d = carry_cnt_q;
    dout_d      = 1'b0;
    done_d      = 1'b0;
`ifdef UNARY_ADD_SAT_EN
    carry_d     = carry_q;
`else
    carry_d     = 1'b0;
`endif

    if (en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = ACCUM;
            count_d     = '0;
            carry_cnt_d = '0;
            carry_d     = 1'b0;
          end
        end

        ACCUM: begin
          if (ovf) begin
`ifdef UNARY_ADD_SAT_EN
            count_d = MAX_CNT;
`else
            count_d = CW'(sum - MOD_S);
`endif
            carry_d     = 1'b1;
            carry_cnt_d = (carry_cnt_q == {CNT_W{1'b1}}) ? carry_cnt_q
                                                         : carry_cnt_q + 1'b1;
          end else begin
            count_d = CW'(sum);
          end
          // The last sample is still folded in before the replay begins.
          if (last) begin
            state_d = EMIT;
          end
        end

        EMIT: begin
          // Count the residue down one pulse per cycle; an empty residue
          // finishes immediately.
          if (count_q != '0) begin
            dout_d  = 1'b1;
            count_d = count_q - 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Controller state and all outputs live in one register bank; reset
  // aborts any operation immediately, discarding a pending replay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      carry_cnt_q <= '0;
      dout_q      <= 1'b0;
      carry_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      carry_cnt_q <= carry_cnt_d;
      dout_q      <= dout_d;
      carry_q     <= carry_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign dout      = dout_q;
  assign carry     = carry_q;
  assign carry_cnt = carry_cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_unary_add_nmod.sv
// ---------------------------------------------------------------------------
// tb_unary_add_nmod
//   Directed bench for unary_add_nmod (MOD=6, N_IN=2, CNT_W=4). Inputs change
//   and outputs are observed on the falling clock edge. Build with
//   +define+UNARY_ADD_SAT_EN to exercise the saturating variant.
// ---------------------------------------------------------------------------
module tb_unary_add_nmod;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       start;
  logic [1:0] din;
  logic       last;
  logic       busy;
  logic       dout;
  logic       carry;
  logic [3:0] carryCnt;
  logic       done;

  int checkCount = 0;
  int errorCount = 0;

  unary_add_nmod #(
    .N_IN  (2),
    .MOD   (6),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .din       (din),
    .last      (last),
    .busy      (busy),
    .dout      (dout),
    .carry     (carry),
    .carry_cnt (carryCnt),
    .done      (done)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, then wait until the next falling edge so the
  // outputs reflect the rising edge that sampled them.
  task automatic applyStimulus(input logic s, input logic [1:0] d,
                               input logic l, input logic e);
    start = s;
    din   = d;
    last  = l;
    en    = e;
    @(negedge clk);
  endtask

  // Compare all outputs at once against the hand-derived expectation.
  task automatic checkOutput(input string tag, input logic expBusy,
                             input logic expDout, input logic expCarry,
                             input logic [3:0] expCnt, input logic expDone);
    logic [7:0] observed;
    logic [7:0] expected;
    observed = {busy, dout, carry, carryCnt, done};
    expected = {expBusy, expDout, expCarry, expCnt, expDone};
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: observed busy/dout/carry/cnt/done=%b_%b_%b_%h_%b expected %b_%b_%b_%h_%b",
             tag, observed[7], observed[6], observed[5], observed[4:1], observed[0],
             expected[7], expected[6], expected[5], expected[4:1], expected[0]);
    end
  endtask

  // Directed scenarios, one after another.
  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    din   = 2'b00;
    last  = 1'b0;

    // Reset while idle.
    #12;
    checkOutput("reset", 0, 0, 0, 4'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("idle_after_reset", 0, 0, 0, 4'd0, 0);

    // 2+2+1 = 5, no wrap: five pulses then done.
    $display("[TB] residue 5 without wrap");
    applyStimulus(1, 2'b00, 0, 1);
    checkOutput("s2_start", 1, 0, 0, 4'd0, 0);
    applyStimulus(0, 2'b11, 0, 1);
    applyStimulus(1, 2'b11, 0, 1);
    checkOutput("s2_start_ignored", 1, 0, 0, 4'd0, 0);
    applyStimulus(0, 2'b01, 1, 1);
    checkOutput("s2_enter_emit", 1, 0, 0, 4'd0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 2'b00, 0, 1);
      checkOutput("s2_pulse", 1, 1, 0, 4'd0, 0);
    end
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("s2_done", 0, 0, 0, 4'd0, 1);
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("s2_done_drop", 0, 0, 0, 4'd0, 0);

    // 2,4,6->wrap,+1: residue 1 (modulo) or clamp at 5 (saturating).
    $display("[TB] wrap scenario");
    applyStimulus(1, 2'b00, 0, 1);
    applyStimulus(0, 2'b11, 0, 1);
    applyStimulus(0, 2'b11, 0, 1);
    checkOutput("s3_no_carry_yet", 1, 0, 0, 4'd0, 0);
    applyStimulus(0, 2'b11, 0, 1);
    checkOutput("s3_carry", 1, 0, 1, 4'd1, 0);
`ifdef UNARY_ADD_SAT_EN
    applyStimulus(0, 2'b01, 1, 1);
    checkOutput("s6_second_ovf", 1, 0, 1, 4'd2, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 2'b00, 0, 1);
      checkOutput("s6_pulse", 1, 1, 1, 4'd2, 0);
    end
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("s6_done", 0, 0, 1, 4'd2, 1);
    applyStimulus(1, 2'b00, 0, 1);
    checkOutput("s6_restart_clears", 1, 0, 0, 4'd0, 0);
`else
    applyStimulus(0, 2'b01, 1, 1);
    checkOutput("s3_carry_drop", 1, 0, 0, 4'd1, 0);
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("s3_pulse", 1, 1, 0, 4'd1, 0);
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("s3_done", 0, 0, 0, 4'd1, 1);
    // Start during the done cycle is accepted.
    applyStimulus(1, 2'b00, 0, 1);
    checkOutput("s3_back_to_back", 1, 0, 0, 4'd0, 0);
`endif

    // Continue the open operation: din and last ignored on the start cycle
    // above, here residue 0 gives done on the first replay cycle.
    $display("[TB] empty residue");
    applyStimulus(0, 2'b00, 1, 1);
    checkOutput("v0_enter_emit", 1, 0, 0, 4'd0, 0);
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("v0_done", 0, 0, 0, 4'd0, 1);

    // Scenario 2 again with a 3-cycle freeze after the second pulse.
    $display("[TB] clock-enable freeze during replay");
    applyStimulus(1, 2'b11, 1, 1);
    applyStimulus(0, 2'b11, 0, 1);
    applyStimulus(0, 2'b11, 0, 1);
    applyStimulus(0, 2'b01, 1, 1);
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("s4_pulse1", 1, 1, 0, 4'd0, 0);
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("s4_pulse2", 1, 1, 0, 4'd0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 2'b11, 1, 0);
      checkOutput("s4_frozen", 1, 0, 0, 4'd0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 2'b00, 0, 1);
      checkOutput("s4_resume_pulse", 1, 1, 0, 4'd0, 0);
    end
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("s4_done", 0, 0, 0, 4'd0, 1);

    // Reset mid-replay with residue 4, then a fresh operation.
    $display("[TB] asynchronous reset during replay");
    applyStimulus(1, 2'b00, 0, 1);
    applyStimulus(0, 2'b11, 0, 1);
    applyStimulus(0, 2'b11, 1, 1);
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("s5_pulse_before_reset", 1, 1, 0, 4'd0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s5_async_abort", 0, 0, 0, 4'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("s5_no_pending_emit", 0, 0, 0, 4'd0, 0);
    applyStimulus(1, 2'b00, 0, 1);
    applyStimulus(0, 2'b11, 1, 1);
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("s5_new_pulse1", 1, 1, 0, 4'd0, 0);
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("s5_new_pulse2", 1, 1, 0, 4'd0, 0);
    applyStimulus(0, 2'b00, 0, 1);
    checkOutput("s5_new_done", 0, 0, 0, 4'd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
